// File: rtl/rf_wr_arbiter_pkg.sv
// Shared widths, write-record type and grant encoding for the RF write-port arbiter.
package rf_wr_arbiter_pkg;

   localparam int unsigned REG_AW = 5;
   localparam int unsigned DATA_W = 32;
   localparam logic [REG_AW-1:0] X0 = '0;

   typedef struct packed {
      logic [REG_AW-1:0] waddr;
      logic [DATA_W-1:0] wdata;
   } rf_wr_t;

   typedef enum logic [1:0] {
      GNT_IDLE,
      GNT_WB,
      GNT_LU
   } grant_e;

   function automatic logic is_x0(input logic [REG_AW-1:0] addr);
      return addr == X0;
   endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// In-order FIFO of pending long-latency RF writes, exposing per-entry valid/waddr
// so decode can detect hazards against every queued destination.
module rf_wb_fifo
   import rf_wr_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           push,
   input  rf_wr_t                         push_data,
   input  logic                           pop,
   output logic                           full,
   output logic                           empty,
   output rf_wr_t                         head,
   output logic [DEPTH-1:0]               ent_valid,
   output logic [DEPTH-1:0][REG_AW-1:0]   ent_waddr
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   rf_wr_t         mem [DEPTH];
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;
   logic [CW-1:0]  count;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         ent_valid <= '0;
      end else begin
         // Clear before set: a same-cycle push can never target the slot being popped
         // because push is blocked while full.
         if (pop) begin
            ent_valid[rd_ptr] <= 1'b0;
            rd_ptr            <= rd_ptr + 1'b1;
         end
         if (push) begin
            ent_valid[wr_ptr] <= 1'b1;
            wr_ptr            <= wr_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   always_comb begin
      ent_waddr = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         ent_waddr[i] = mem[i].waddr;
      end
   end

endmodule

// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter: WB has priority, LU results queue in rf_wb_fifo.
// Define RF_ARB_AGE_EN to force the LU head through after AGE_MAX denied cycles.
module rf_wr_arbiter
   import rf_wr_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH   = 2,
   parameter int unsigned AGE_MAX = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wb_we_i,
   input  logic [REG_AW-1:0] wb_waddr_i,
   input  logic [DATA_W-1:0] wb_wdata_i,
   input  logic              lu_valid_i,
   output logic              lu_ready_o,
   input  logic [REG_AW-1:0] lu_waddr_i,
   input  logic [DATA_W-1:0] lu_wdata_i,
   input  logic [REG_AW-1:0] rs1_addr_i,
   input  logic [REG_AW-1:0] rs2_addr_i,
   output logic              rs1_pend_o,
   output logic              rs2_pend_o,
   output logic              wb_stall_o,
   output logic              rf_we_o,
   output logic [REG_AW-1:0] rf_waddr_o,
   output logic [DATA_W-1:0] rf_wdata_o
);

   logic                          full;
   logic                          empty;
   logic                          wb_req;
   logic                          lu_push;
   logic                          lu_pop;
   logic                          age_force;
   rf_wr_t                        head;
   logic [DEPTH-1:0]              ent_valid;
   logic [DEPTH-1:0][REG_AW-1:0]  ent_waddr;
   grant_e                        grant;

   assign lu_ready_o = !full;
   assign lu_push    = lu_valid_i && !full && !is_x0(lu_waddr_i);
   assign wb_req     = wb_we_i && !is_x0(wb_waddr_i);
   assign lu_pop     = (grant == GNT_LU);

   rf_wb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (lu_push),
      .push_data ('{waddr: lu_waddr_i, wdata: lu_wdata_i}),
      .pop       (lu_pop),
      .full      (full),
      .empty     (empty),
      .head      (head),
      .ent_valid (ent_valid),
      .ent_waddr (ent_waddr)
   );

`ifdef RF_ARB_AGE_EN
   localparam int unsigned AW = $clog2(AGE_MAX + 1);
   logic [AW-1:0] age;

   assign age_force  = !empty && (age == AW'(AGE_MAX));
   assign wb_stall_o = age_force && wb_req;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                age <= '0;
      else if (empty || lu_pop)  age <= '0;
      else                       age <= age + 1'b1;
   end
`else
   assign age_force  = 1'b0;
   assign wb_stall_o = 1'b0;
`endif

   always_comb begin
      grant = GNT_IDLE;
      if (age_force)    grant = GNT_LU;
      else if (wb_req)  grant = GNT_WB;
      else if (!empty)  grant = GNT_LU;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_we_o    <= 1'b0;
         rf_waddr_o <= '0;
         rf_wdata_o <= '0;
      end else begin
         case (grant)
            GNT_WB: begin
               rf_we_o    <= 1'b1;
               rf_waddr_o <= wb_waddr_i;
               rf_wdata_o <= wb_wdata_i;
            end
            GNT_LU: begin
               rf_we_o    <= 1'b1;
               rf_waddr_o <= head.waddr;
               rf_wdata_o <= head.wdata;
            end
            default: rf_we_o <= 1'b0;
         endcase
      end
   end

   // The entry popped this cycle is still valid here, so decode keeps stalling until it lands.
   always_comb begin
      rs1_pend_o = 1'b0;
      rs2_pend_o = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (ent_valid[i] && !is_x0(rs1_addr_i) && ent_waddr[i] == rs1_addr_i) rs1_pend_o = 1'b1;
         if (ent_valid[i] && !is_x0(rs2_addr_i) && ent_waddr[i] == rs2_addr_i) rs2_pend_o = 1'b1;
      end
   end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed vector bench for rf_wr_arbiter; follows RF_ARB_AGE_EN if defined for the build.
module tb_rf_wr_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wb_we_i;
   logic [4:0]  wb_waddr_i;
   logic [31:0] wb_wdata_i;
   logic        lu_valid_i;
   logic        lu_ready_o;
   logic [4:0]  lu_waddr_i;
   logic [31:0] lu_wdata_i;
   logic [4:0]  rs1_addr_i;
   logic [4:0]  rs2_addr_i;
   logic        rs1_pend_o;
   logic        rs2_pend_o;
   logic        wb_stall_o;
   logic        rf_we_o;
   logic [4:0]  rf_waddr_o;
   logic [31:0] rf_wdata_o;

`ifdef RF_ARB_AGE_EN
   localparam bit AGE_EN = 1'b1;
`else
   localparam bit AGE_EN = 1'b0;
`endif

   rf_wr_arbiter #(
      .DEPTH   (2),
      .AGE_MAX (8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wb_we_i    (wb_we_i),
      .wb_waddr_i (wb_waddr_i),
      .wb_wdata_i (wb_wdata_i),
      .lu_valid_i (lu_valid_i),
      .lu_ready_o (lu_ready_o),
      .lu_waddr_i (lu_waddr_i),
      .lu_wdata_i (lu_wdata_i),
      .rs1_addr_i (rs1_addr_i),
      .rs2_addr_i (rs2_addr_i),
      .rs1_pend_o (rs1_pend_o),
      .rs2_pend_o (rs2_pend_o),
      .wb_stall_o (wb_stall_o),
      .rf_we_o    (rf_we_o),
      .rf_waddr_o (rf_waddr_o),
      .rf_wdata_o (rf_wdata_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wb_we;
      logic [4:0]  wb_a;
      logic [31:0] wb_d;
      logic        lu_v;
      logic [4:0]  lu_a;
      logic [31:0] lu_d;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        rdy;
      logic        p1;
      logic        p2;
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
   } vec_t;

   vec_t vt [20];
   int   n_chk = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic lv, input logic [4:0] la, input logic [31:0] ld);
      wb_we_i    = we;
      wb_waddr_i = wa;
      wb_wdata_i = wd;
      lu_valid_i = lv;
      lu_waddr_i = la;
      lu_wdata_i = ld;
   endtask

   initial begin
      // wb_we wb_a wb_d | lu_v lu_a lu_d | rs1 rs2 | rdy p1 p2 | we wa wd (after edge)
      vt[0]  = '{1, 5, 32'h11, 0, 0, 0,      0, 0, 1, 0, 0, 1, 5, 32'h11};
      vt[1]  = '{0, 0, 0,      0, 0, 0,      0, 0, 1, 0, 0, 0, 0, 0};
      vt[2]  = '{1, 3, 32'h30, 1, 7, 32'hAA, 7, 0, 1, 0, 0, 1, 3, 32'h30};
      vt[3]  = '{1, 3, 32'h31, 0, 0, 0,      7, 0, 1, 1, 0, 1, 3, 32'h31};
      vt[4]  = '{1, 3, 32'h32, 0, 0, 0,      7, 0, 1, 1, 0, 1, 3, 32'h32};
      vt[5]  = '{1, 3, 32'h33, 0, 0, 0,      7, 0, 1, 1, 0, 1, 3, 32'h33};
      vt[6]  = '{0, 0, 0,      0, 0, 0,      7, 0, 1, 1, 0, 1, 7, 32'hAA};
      vt[7]  = '{0, 0, 0,      0, 0, 0,      7, 0, 1, 0, 0, 0, 0, 0};
      vt[8]  = '{1, 4, 32'h40, 1, 1, 32'hA1, 0, 0, 1, 0, 0, 1, 4, 32'h40};
      vt[9]  = '{1, 4, 32'h41, 1, 2, 32'hA2, 1, 0, 1, 1, 0, 1, 4, 32'h41};
      vt[10] = '{1, 4, 32'h42, 1, 3, 32'hA3, 1, 2, 0, 1, 1, 1, 4, 32'h42};
      vt[11] = '{0, 0, 0,      1, 3, 32'hA3, 1, 2, 0, 1, 1, 1, 1, 32'hA1};
      vt[12] = '{0, 0, 0,      1, 3, 32'hA3, 1, 2, 1, 0, 1, 1, 2, 32'hA2};
      vt[13] = '{0, 0, 0,      0, 0, 0,      3, 2, 1, 1, 0, 1, 3, 32'hA3};
      vt[14] = '{0, 0, 0,      0, 0, 0,      3, 0, 1, 0, 0, 0, 0, 0};
      vt[15] = '{0, 0, 0,      1, 0, 32'h55, 0, 0, 1, 0, 0, 0, 0, 0};
      vt[16] = '{0, 0, 0,      0, 0, 0,      0, 0, 1, 0, 0, 0, 0, 0};
      vt[17] = '{1, 4, 32'h50, 1, 6, 32'h66, 0, 6, 1, 0, 0, 1, 4, 32'h50};
      vt[18] = '{1, 0, 32'h77, 0, 0, 0,      6, 6, 1, 1, 1, 1, 6, 32'h66};
      vt[19] = '{0, 0, 0,      0, 0, 0,      6, 6, 1, 0, 0, 0, 0, 0};

      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      rs1_addr_i = '0;
      rs2_addr_i = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk("rst_we", {31'd0, rf_we_o}, 0);
      chk("rst_waddr", {27'd0, rf_waddr_o}, 0);
      chk("rst_wdata", rf_wdata_o, 0);
      chk("rst_ready", {31'd0, lu_ready_o}, 1);
      chk("rst_stall", {31'd0, wb_stall_o}, 0);

      // Reset mid-stream with two entries queued
      @(posedge clk); #1;
      drive(1, 4, 32'hE0, 1, 1, 32'hE1);
      @(posedge clk); #1;
      drive(1, 4, 32'hE2, 1, 2, 32'hE2);
      @(posedge clk); #1;
      drive(1, 4, 32'hE3, 0, 0, 0);
      @(negedge clk);
      chk("mid_full_ready", {31'd0, lu_ready_o}, 0);
      chk("mid_we_before_rst", {31'd0, rf_we_o}, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_async_we", {31'd0, rf_we_o}, 0);
      drive(0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n      = 1'b1;
      rs1_addr_i = 5'd1;
      rs2_addr_i = 5'd2;
      #1;
      chk("post_rst_ready", {31'd0, lu_ready_o}, 1);
      chk("post_rst_p1", {31'd0, rs1_pend_o}, 0);
      chk("post_rst_p2", {31'd0, rs2_pend_o}, 0);
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         chk($sformatf("post_rst_idle%0d_we", c), {31'd0, rf_we_o}, 0);
      end

      // Table-driven vectors
      for (int i = 0; i < 20; i++) begin
         drive(vt[i].wb_we, vt[i].wb_a, vt[i].wb_d, vt[i].lu_v, vt[i].lu_a, vt[i].lu_d);
         rs1_addr_i = vt[i].rs1;
         rs2_addr_i = vt[i].rs2;
         @(negedge clk);
         chk($sformatf("v%0d_ready", i), {31'd0, lu_ready_o}, {31'd0, vt[i].rdy});
         chk($sformatf("v%0d_p1", i), {31'd0, rs1_pend_o}, {31'd0, vt[i].p1});
         chk($sformatf("v%0d_p2", i), {31'd0, rs2_pend_o}, {31'd0, vt[i].p2});
         chk($sformatf("v%0d_stall", i), {31'd0, wb_stall_o}, 0);
         @(posedge clk); #1;
         chk($sformatf("v%0d_we", i), {31'd0, rf_we_o}, {31'd0, vt[i].we});
         if (vt[i].we) begin
            chk($sformatf("v%0d_waddr", i), {27'd0, rf_waddr_o}, {27'd0, vt[i].wa});
            chk($sformatf("v%0d_wdata", i), rf_wdata_o, vt[i].wd);
         end
      end

      // Ageing: WB busy every cycle with one LU entry queued
      begin
         int unsigned k;
         logic        exp_stall;
         drive(1, 4, 32'h100, 1, 8, 32'h88);
         rs1_addr_i = 5'd8;
         rs2_addr_i = 5'd0;
         @(posedge clk); #1;
         chk("age_c0_waddr", {27'd0, rf_waddr_o}, 4);
         k = 1;
         for (int c = 1; c <= 12; c++) begin
            drive(1, 4, 32'h100 + k, 0, 0, 0);
            exp_stall = AGE_EN && (c == 9);
            @(negedge clk);
            chk($sformatf("age_c%0d_stall", c), {31'd0, wb_stall_o}, {31'd0, exp_stall});
            chk($sformatf("age_c%0d_p1", c), {31'd0, rs1_pend_o},
                (AGE_EN && c > 9) ? 32'd0 : 32'd1);
            @(posedge clk); #1;
            chk($sformatf("age_c%0d_we", c), {31'd0, rf_we_o}, 1);
            if (exp_stall) begin
               chk($sformatf("age_c%0d_waddr", c), {27'd0, rf_waddr_o}, 8);
               chk($sformatf("age_c%0d_wdata", c), rf_wdata_o, 32'h88);
            end else begin
               chk($sformatf("age_c%0d_waddr", c), {27'd0, rf_waddr_o}, 4);
               chk($sformatf("age_c%0d_wdata", c), rf_wdata_o, 32'h100 + k);
               k++;
            end
         end
         drive(0, 0, 0, 0, 0, 0);
         @(posedge clk); #1;
         if (AGE_EN) begin
            chk("age_tail_we", {31'd0, rf_we_o}, 0);
         end else begin
            chk("age_tail_we", {31'd0, rf_we_o}, 1);
            chk("age_tail_waddr", {27'd0, rf_waddr_o}, 8);
            chk("age_tail_wdata", rf_wdata_o, 32'h88);
         end
         @(posedge clk); #1;
         chk("age_final_we", {31'd0, rf_we_o}, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

endmodule
